// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient controller and its bank.
package fir_pkg;

  localparam int COEF_W     = 16;
  localparam int N_TAPS_DEF = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_FILL  = 2'd1,
    L_ARMED = 2'd2
  } load_state_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } mode_t;

  // Width of one tap slice on the flat coefficient bus.
  localparam int SLICE_W = COEF_W;

  function automatic int flat_w(input int bw, input int n);
    return bw * n;
  endfunction

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Sample stream, coefficient load and status signals of fir_coef_ctrl.
interface fir_coef_ctrl_if #(
  parameter int BITWIDTH = 16,
  parameter int N        = 16
);
  logic                  in_valid;
  logic [BITWIDTH-1:0]   in_data;
  logic                  in_ready;
  logic                  fir_enable;
  logic [BITWIDTH-1:0]   fir_inP;
  logic [BITWIDTH*N-1:0] coeffs;
  logic                  ld_valid;
  logic [BITWIDTH-1:0]   ld_data;
  logic                  ld_last;
  logic                  ld_ready;
  logic                  commit;
  logic                  bank_id;
  logic                  busy;
  logic                  error;
  logic                  err_clr;

  modport slave (
    input  in_valid, in_data, ld_valid, ld_data, ld_last, commit, err_clr,
    output in_ready, fir_enable, fir_inP, coeffs, ld_ready, bank_id, busy, error
  );

  modport master (
    output in_valid, in_data, ld_valid, ld_data, ld_last, commit, err_clr,
    input  in_ready, fir_enable, fir_inP, coeffs, ld_ready, bank_id, busy, error
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient register banks; the swap strobe copies the
// whole shadow bank into the active bank in one edge.
module fir_coef_bank #(
  parameter int BITWIDTH = 16,
  parameter int N        = 16,
  parameter int IDXW     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_we,
  input  logic [IDXW-1:0]       i_idx,
  input  logic [BITWIDTH-1:0]   i_data,
  input  logic                  i_swap,
  output logic [BITWIDTH*N-1:0] o_coeffs
);

  logic [BITWIDTH-1:0] r_shadow [N];
  logic [BITWIDTH-1:0] r_active [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_shadow[gi] <= '0;
          r_active[gi] <= '0;
        end else begin
          if (i_we && (i_idx == IDXW'(gi))) begin
            r_shadow[gi] <= i_data;
          end
          if (i_swap) begin
            r_active[gi] <= r_shadow[gi];
          end
        end
      end

      assign o_coeffs[BITWIDTH*gi +: BITWIDTH] = r_active[gi];
    end
  endgenerate

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient load/commit controller in front of the FIR block.
// Optional post-swap delay-line flush: define FIR_COEF_CTRL_FLUSH_EN.
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int BITWIDTH = COEF_W,
  parameter int N        = N_TAPS_DEF,
  parameter int IDXW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           resetn,
  fir_coef_ctrl_if.slave bus
);

  load_state_t     r_state, w_state_next;
  logic [IDXW-1:0] r_idx, w_idx_next;
  logic            r_pending, w_pending_next;
  logic            r_error, w_error_next;
  logic            r_bank_id;
  logic            w_ld_ready;
  logic            w_ld_fire;
  logic            w_is_last_idx;
  logic            w_frame_err;
  logic            w_fill_done;
  logic            w_swap;
  logic            w_flushing;

  assign w_ld_ready    = (r_state != L_ARMED);
  assign w_ld_fire     = bus.ld_valid & w_ld_ready;
  assign w_is_last_idx = (r_idx == IDXW'(N - 1));
  // ld_last must coincide exactly with the final tap; anything else is a framing error.
  assign w_frame_err   = w_ld_fire & (bus.ld_last != w_is_last_idx);
  assign w_fill_done   = w_ld_fire & bus.ld_last & w_is_last_idx;
  assign w_swap        = (r_state == L_ARMED) & (r_pending | bus.commit);

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_pending_next = r_pending;
    w_error_next   = r_error;

    case (r_state)
      L_IDLE, L_FILL: begin
        if (w_ld_fire) begin
          if (w_frame_err) begin
            w_state_next = L_IDLE;
            w_idx_next   = '0;
          end else if (w_fill_done) begin
            w_state_next = L_ARMED;
            w_idx_next   = '0;
          end else begin
            w_state_next = L_FILL;
            w_idx_next   = IDXW'(r_idx + 1'b1);
          end
        end
        if (bus.commit && (r_state == L_FILL)) begin
          w_pending_next = 1'b1;
        end
      end
      L_ARMED: begin
        if (bus.commit) begin
          w_pending_next = 1'b1;
        end
        if (w_swap) begin
          w_state_next = L_IDLE;
        end
      end
      default: begin
        w_state_next = L_IDLE;
        w_idx_next   = '0;
      end
    endcase

    if (w_swap || w_frame_err) begin
      w_pending_next = 1'b0;
    end

    // A fresh error outranks a simultaneous clear.
    if (w_frame_err) begin
      w_error_next = 1'b1;
    end else if (bus.err_clr) begin
      w_error_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= L_IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_error   <= 1'b0;
      r_bank_id <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_pending <= w_pending_next;
      r_error   <= w_error_next;
      if (w_swap) begin
        r_bank_id <= ~r_bank_id;
      end
    end
  end

  fir_coef_bank #(
    .BITWIDTH (BITWIDTH),
    .N        (N),
    .IDXW     (IDXW)
  ) u_bank (
    .clk      (clk),
    .resetn   (resetn),
    .i_we     (w_ld_fire),
    .i_idx    (r_idx),
    .i_data   (bus.ld_data),
    .i_swap   (w_swap),
    .o_coeffs (bus.coeffs)
  );

`ifdef FIR_COEF_CTRL_FLUSH_EN
  mode_t           r_mode, w_mode_next;
  logic [IDXW-1:0] r_flush_cnt, w_flush_cnt_next;

  // Every swap (including one during a flush) restarts an N-cycle flush.
  always_comb begin
    w_mode_next      = r_mode;
    w_flush_cnt_next = r_flush_cnt;
    if (w_swap) begin
      w_mode_next      = FLUSH;
      w_flush_cnt_next = IDXW'(N - 1);
    end else if (r_mode == FLUSH) begin
      if (r_flush_cnt == '0) begin
        w_mode_next = RUN;
      end else begin
        w_flush_cnt_next = IDXW'(r_flush_cnt - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mode      <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_mode      <= w_mode_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  assign w_flushing = (r_mode == FLUSH);
`else
  assign w_flushing = 1'b0;
`endif

  assign bus.in_ready   = ~w_flushing;
  assign bus.fir_enable = resetn & (w_flushing | bus.in_valid);
  assign bus.fir_inP    = w_flushing ? '0 : bus.in_data;
  assign bus.ld_ready   = w_ld_ready;
  assign bus.bank_id    = r_bank_id;
  assign bus.error      = r_error;
  assign bus.busy       = (r_state != L_IDLE) | w_flushing;

endmodule
